// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces a raw pushbutton pin and emits a clean
// pressed level, one-cycle press/release/long-press pulses and a wrapping press count.
//
// Ports:
//   clk           - sole clock, rising edge
//   rst_n         - asynchronous active-low reset
//   btn_in        - raw asynchronous button pin
//   btn_level     - debounced pressed level (1 = pressed)
//   press_pulse   - one-cycle pulse on each debounced press
//   release_pulse - one-cycle pulse on each debounced release
//   long_pulse    - one-cycle pulse after a long hold, at most once per press
//   press_count   - count of debounced presses, wraps 255 -> 0
//
// Build option: define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the long-press state,
// hold counter and long_pulse. Without it long_pulse is tied low.
module button_debounce #(
  parameter int unsigned DB_CYCLES   = 250000,
  parameter int unsigned LONG_CYCLES = 12000000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned   DbW    = $clog2(DB_CYCLES);
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

  // Two-flop synchronizer, reset to the released pin value.
  logic sync0_q, sync1_q;
  logic s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= ACTIVE_LOW;
      sync1_q <= ACTIVE_LOW;
    end else begin
      sync0_q <= btn_in;
      sync1_q <= sync0_q;
    end
  end

  // Normalized: 1 = pressed regardless of pin polarity.
  assign s = sync1_q ^ ACTIVE_LOW;

  // Debounce: any return to the current level restarts the count.
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           rise, fall;

  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (s == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      level_d  = s;
      db_cnt_d = '0;
      rise     = s;
      fall     = ~s;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

  localparam int unsigned      HoldW    = $clog2(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;
`else
  typedef enum logic [1:0] {StIdle, StPressed} state_e;
`endif

  state_e     state_q, state_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic [7:0] count_q, count_d;

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    long_d    = 1'b0;
    hold_d    = hold_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        hold_d = '0;
`endif
        if (rise) begin
          state_d = StPressed;
          press_d = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      StPressed: begin
        // A release on the terminal hold edge takes priority over the long event.
        if (fall) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        else if (hold_q == HoldLast) begin
          state_d = StLong;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      StLong: begin
        // Hold counter frozen here so long_pulse cannot repeat within one press.
        if (fall) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= StIdle;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce with DB_CYCLES=4, LONG_CYCLES=20,
// ACTIVE_LOW=1. Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, so a pin change made after edge E0 shows up on edge E0+6.
module tb_button_debounce;

  localparam int unsigned DbCycles   = 4;
  localparam int unsigned LongCycles = 20;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int unsigned n_pass;
  int unsigned n_total;
  logic [7:0]  exp_cnt;

  button_debounce #(
    .DB_CYCLES  (DbCycles),
    .LONG_CYCLES(LongCycles),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic lvl, input logic pr, input logic rl,
                         input logic lg, input logic [7:0] cnt);
    chk({tag, ".level"}, {7'd0, btn_level}, {7'd0, lvl});
    chk({tag, ".press"}, {7'd0, press_pulse}, {7'd0, pr});
    chk({tag, ".release"}, {7'd0, release_pulse}, {7'd0, rl});
    chk({tag, ".long"}, {7'd0, long_pulse}, {7'd0, lg});
    chk({tag, ".count"}, press_count, cnt);
  endtask

  // Pin pressed after the current edge; press lands on the sixth edge.
  task automatic do_press(input string tag);
    btn_in = 1'b0;
    repeat (5) begin
      tick();
      chk({tag, ".pre_press"}, {7'd0, press_pulse}, 8'd0);
    end
    tick();
    exp_cnt = exp_cnt + 8'd1;
    chk_all({tag, ".press_edge"}, 1'b1, 1'b1, 1'b0, 1'b0, exp_cnt);
  endtask

  task automatic do_release(input string tag);
    btn_in = 1'b1;
    repeat (5) begin
      tick();
      chk({tag, ".pre_release"}, {7'd0, release_pulse}, 8'd0);
    end
    tick();
    chk_all({tag, ".release_edge"}, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    exp_cnt = 8'd0;
    rst_n   = 1'b0;
    btn_in  = 1'b1;

    // Reset held with the pin toggling: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      btn_in = ~btn_in;
      tick();
      chk_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    btn_in = 1'b1;
    rst_n  = 1'b1;
    repeat (8) begin
      tick();
      chk_all("reset_release", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // Clean press and release.
    do_press("clean");
    tick();
    chk_all("clean.after", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    repeat (3) tick();
    do_release("clean");
    tick();
    chk_all("clean.rel_after", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // Bounce: low 3, high 1, then low for good. Debounce restarts at the final low.
    btn_in = 1'b0;
    repeat (3) begin
      tick();
      chk("bounce.low", {7'd0, press_pulse}, 8'd0);
    end
    btn_in = 1'b1;
    tick();
    chk("bounce.high", {7'd0, press_pulse}, 8'd0);
    do_press("bounce");
    tick();
    chk("bounce.after", {7'd0, press_pulse}, 8'd0);
    do_release("bounce");

    // Lone 3-cycle glitch: counter reaches 3 but never commits.
    btn_in = 1'b0;
    repeat (3) tick();
    btn_in = 1'b1;
    repeat (10) begin
      tick();
      chk_all("glitch", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
    end

    // Long press: long_pulse exactly 20 edges after press_pulse, only once.
    do_press("long");
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("long.pulse", {7'd0, long_pulse}, {7'd0, (LongEn && (i == 20))});
      chk("long.level", {7'd0, btn_level}, 8'd1);
      chk("long.no_press", {7'd0, press_pulse}, 8'd0);
    end
    do_release("long");

    // Collision: release debounced on the edge where hold counter is terminal.
    do_press("coll");
    repeat (14) tick();
    btn_in = 1'b1;
    repeat (5) begin
      tick();
      chk("coll.pre_long", {7'd0, long_pulse}, 8'd0);
    end
    tick();
    chk_all("coll.edge", 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt);
    repeat (25) begin
      tick();
      chk("coll.idle_long", {7'd0, long_pulse}, 8'd0);
    end

    // Wrap: count goes through 255 back to 0.
    for (int i = 0; i < 252; i++) begin
      do_press("wrap");
      do_release("wrap");
    end
    chk("wrap.zero", press_count, 8'd0);

    // Reset mid-press, button held across deassertion.
    do_press("mid");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_all("mid.in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    tick();
    exp_cnt = 8'd0;
    rst_n   = 1'b1;
    do_press("mid_after");
    tick();
    chk_all("mid.after", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input-side companion to the RGB blink counter: synchronizes and debounces a raw pushbutton, then emits clean level, press, release and long-press events plus a wrapping press count. It sits between the board button pin and the LED/blink control logic, so the user can step blink rate or colour mode without glitches.

## Interface
- `DB_CYCLES`, default 250000: cycles the synchronized input must differ from the debounced level before the level changes. Legal range is ≥ 2.
- `LONG_CYCLES`, default 12000000: cycles of continuous debounced press before `long_pulse` fires. Legal range is > `DB_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed; 0 means the pin reads 1 when pressed.
- `clk`, input, 1: sole clock. All flops are rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn_in`, input, 1: raw asynchronous button pin.
- `btn_level`, output, 1: debounced pressed level, 1 = pressed.
- `press_pulse`, output, 1: one-cycle pulse on each debounced press.
- `release_pulse`, output, 1: one-cycle pulse on each debounced release.
- `long_pulse`, output, 1: one-cycle pulse, at most once per press.
- `press_count`, output, 8: count of debounced presses, wraps 255→0.

## Operation
- **Synchronizer.** Two-flop synchronizer on `btn_in`, then polarity normalize: `s = sync1 ^ ACTIVE_LOW`, so `s` = 1 means pressed. Sync flops reset to the released pin value (`ACTIVE_LOW`).
- **Debounce counter.** `db_cnt` is `$clog2(DB_CYCLES)` bits wide.
  - If `s == btn_level`: `db_cnt <= 0`.
  - Otherwise, if `db_cnt == DB_CYCLES-1`: `btn_level <= s` and `db_cnt <= 0`.
  - Otherwise: `db_cnt <= db_cnt + 1`.
  - Any bounce back to `btn_level` restarts the count from 0.
- **FSM.** States are IDLE, PRESSED and LONG.
  - IDLE → PRESSED on a debounced rise. `press_pulse` = 1 and `press_count` increments.
  - PRESSED → LONG when `hold_cnt == LONG_CYCLES-1`. `long_pulse` = 1.
  - PRESSED or LONG → IDLE on a debounced fall. `release_pulse` = 1.
- **Hold counter.** `hold_cnt` is `$clog2(LONG_CYCLES)` bits wide.
  - Cleared in IDLE.
  - Increments every cycle in PRESSED.
  - Frozen in LONG; no further `long_pulse` until the next press.
- **Registered outputs.** All pulses are registered: high for exactly one cycle, in the same cycle `btn_level` changes (or, for `long_pulse`, the same cycle the state enters LONG).
- **Reset values.** `btn_level` = 0, all pulses = 0, `press_count` = 0, state = IDLE, both counters = 0.
- **Reset mid-press.** All state clears. If the button is still held after `rst_n` deasserts, it is detected as a fresh press after the normal debounce latency.

## Timing
- **Press/release latency.** Suppose `btn_in` settles just before rising edge k. `btn_level` and `press_pulse` (or `release_pulse`) assert at edge k+1+`DB_CYCLES`.
- **Long-press latency.** `long_pulse` asserts `LONG_CYCLES` cycles after `press_pulse`, i.e. `press_pulse` at edge p gives `long_pulse` at edge p+`LONG_CYCLES`.
- **Release/long collision.** If the release is debounced on the same edge that `hold_cnt` reaches terminal, release wins: `release_pulse` = 1, `long_pulse` = 0, next state IDLE.
- **Pulse exclusivity.** `press_pulse` and `release_pulse` are never both high. Minimum spacing between them is `DB_CYCLES` cycles.
- **Count visibility.** `press_count` updates on the same edge as `press_pulse`, visible the following cycle.
- **Wrap.** `press_count` wraps 255→0 with no flag.

## Configuration
- Macro: `BUTTON_DEBOUNCE_LONG_PRESS_EN`.
- **Defined:** the LONG state, `hold_cnt` and `long_pulse` behave as above.
- **Undefined:**
  - No LONG state and no `hold_cnt` logic is built.
  - `long_pulse` is tied to 0.
  - The FSM reduces to IDLE ↔ PRESSED.
  - Other outputs are unchanged cycle-for-cycle.

## Test plan
Bench parameters: `DB_CYCLES`=4, `LONG_CYCLES`=20, `ACTIVE_LOW`=1.

- **Reset values.** Hold `rst_n`=0 with `btn_in` toggling → all outputs 0. Release reset with `btn_in`=1 → outputs stay 0.
- **Clean press.** `btn_in` 1→0 before edge k → `btn_level`=1 and `press_pulse` high for one cycle at edge k+5. `press_count` reads 1. `release_pulse` stays 0.
- **Bounce rejection.**
  - Pulse `btn_in` low for 3 cycles, high 1 cycle, low again → no `press_pulse` until 4+1 cycles after the final low is synchronized.
  - A 3-cycle low glitch alone → no events.
- **Long press.**
  - Hold pressed for 30 cycles → `long_pulse` exactly once, 20 cycles after `press_pulse`.
  - Then release → `release_pulse` once, 5 cycles after the pin rises.
  - With the macro undefined → `long_pulse` never rises.
- **Release/long collision.** Time the debounced release onto the `hold_cnt`=19 edge → `release_pulse`=1, `long_pulse`=0, state IDLE.
- **Count wrap and reset mid-press.**
  - 256 clean presses → `press_count` returns to 0.
  - Assert `rst_n`=0 mid-press, then deassert with the button held → `press_count`=0, then a new `press_pulse` 5 cycles after the deassert edge and `press_count`=1.
